// File: rtl/regfile_wb_sched_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// regfile_pkg : shared types for the register-file write-back scheduler
// Rev 1.0
// ------------------------------------------------------------------
package regfile_pkg;

  localparam int unsigned HALF_W = 16;

  typedef logic [4:0]        reg_idx_t;
  typedef logic [HALF_W-1:0] half_t;

  typedef struct packed {
    reg_idx_t    rd;
    logic [31:0] result;
    logic        wide;
    logic        half;
  } wb_req_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HIGH = 1'b1
  } wb_state_e;

endpackage
`default_nettype wire

// File: rtl/regfile_wb_sched_if.sv
`default_nettype none
// ------------------------------------------------------------------
// regfile_wb_sched_if : ALU/load-unit requests and register-file write port
// Rev 1.0
// ------------------------------------------------------------------
interface regfile_wb_sched_if;
  import regfile_pkg::*;

  logic        alu_valid;
  logic        alu_ready;
  reg_idx_t    alu_rd;
  logic [31:0] alu_result;
  logic        alu_wide;
  logic        alu_half;

  logic        mem_valid;
  logic        mem_ready;
  reg_idx_t    mem_rd;
  logic [31:0] mem_result;
  logic        mem_wide;
  logic        mem_half;

  logic        rw_clken;
  logic        rw_half;
  reg_idx_t    rw_rd;
  half_t       rw_result;
  logic        busy;

  modport master (
    output alu_valid, alu_rd, alu_result, alu_wide, alu_half,
    output mem_valid, mem_rd, mem_result, mem_wide, mem_half,
    input  alu_ready, mem_ready,
    input  rw_clken, rw_half, rw_rd, rw_result, busy
  );

  modport slave (
    input  alu_valid, alu_rd, alu_result, alu_wide, alu_half,
    input  mem_valid, mem_rd, mem_result, mem_wide, mem_half,
    output alu_ready, mem_ready,
    output rw_clken, rw_half, rw_rd, rw_result, busy
  );

endinterface
`default_nettype wire

// File: rtl/regfile_wb_sched_pick.sv
`default_nettype none
// ------------------------------------------------------------------
// regfile_wb_pick : two-way combinational picker, one-hot grant {mem, alu}
// Rev 1.0
// ------------------------------------------------------------------
module regfile_wb_pick (
  input  wire logic       alu_valid_i,
  input  wire logic       mem_valid_i,
  input  wire logic       prio_mem_i,
  output logic [1:0]      gnt_o
);

  // The favoured side wins whenever it is valid; the other only when alone.
  assign gnt_o[1] = mem_valid_i & (prio_mem_i | ~alu_valid_i);
  assign gnt_o[0] = alu_valid_i & (~prio_mem_i | ~mem_valid_i);

endmodule
`default_nettype wire

// File: rtl/regfile_wb_sched.sv
`default_nettype none
// ------------------------------------------------------------------
// regfile_wb_sched : arbitrates ALU/load write-backs and splits 32-bit
// results into 16-bit beats. REGFILE_WB_RR_EN selects round-robin.
// Rev 1.0
// ------------------------------------------------------------------
module regfile_wb_sched
  import regfile_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  wire logic          clk,
  input  wire logic          rst,
  regfile_wb_sched_if.slave  bus
);

  wb_state_e state_q, state_d;
  reg_idx_t  hi_rd_q, hi_rd_d;
  half_t     hi_data_q, hi_data_d;
  logic      rw_clken_q, rw_clken_d;
  logic      rw_half_q, rw_half_d;
  reg_idx_t  rw_rd_q, rw_rd_d;
  half_t     rw_result_q, rw_result_d;

  logic       prio_mem;
  logic [1:0] gnt;
  logic       ready_ok;
  logic       mem_acc;
  logic       alu_acc;
  logic       acc;
  wb_req_t    req;

  regfile_wb_pick u_pick (
    .alu_valid_i (bus.alu_valid),
    .mem_valid_i (bus.mem_valid),
    .prio_mem_i  (prio_mem),
    .gnt_o       (gnt)
  );

  assign ready_ok      = (state_q == IDLE) & ~rst;
  assign bus.mem_ready = ready_ok & gnt[1];
  assign bus.alu_ready = ready_ok & gnt[0];

  assign mem_acc = bus.mem_ready & bus.mem_valid;
  assign alu_acc = bus.alu_ready & bus.alu_valid;
  assign acc     = mem_acc | alu_acc;

  always_comb begin
    if (mem_acc) begin
      req = '{rd: bus.mem_rd, result: bus.mem_result, wide: bus.mem_wide, half: bus.mem_half};
    end else begin
      req = '{rd: bus.alu_rd, result: bus.alu_result, wide: bus.alu_wide, half: bus.alu_half};
    end
  end

`ifdef REGFILE_WB_RR_EN
  logic prio_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= 1'b1;
    end else if (acc && bus.mem_valid && bus.alu_valid) begin
      prio_q <= ~prio_q;
    end
  end

  assign prio_mem = prio_q;
`else
  assign prio_mem = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    hi_rd_d     = hi_rd_q;
    hi_data_d   = hi_data_q;
    rw_clken_d  = 1'b0;
    rw_half_d   = rw_half_q;
    rw_rd_d     = rw_rd_q;
    rw_result_d = rw_result_q;

    case (state_q)
      HIGH: begin
        rw_clken_d  = 1'b1;
        rw_half_d   = 1'b1;
        rw_rd_d     = hi_rd_q;
        rw_result_d = hi_data_q;
        state_d     = IDLE;
      end
      default: begin
        // Writes to register 0 are swallowed: no beat, no high phase.
        if (acc && (req.rd != '0)) begin
          rw_clken_d  = 1'b1;
          rw_half_d   = req.wide ? 1'b0 : req.half;
          rw_rd_d     = req.rd;
          rw_result_d = req.result[HALF_W-1:0];
          if (req.wide) begin
            state_d   = HIGH;
            hi_rd_d   = req.rd;
            hi_data_d = req.result[XLEN-1:HALF_W];
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hi_rd_q     <= '0;
      hi_data_q   <= '0;
      rw_clken_q  <= 1'b0;
      rw_half_q   <= 1'b0;
      rw_rd_q     <= '0;
      rw_result_q <= '0;
    end else begin
      state_q     <= state_d;
      hi_rd_q     <= hi_rd_d;
      hi_data_q   <= hi_data_d;
      rw_clken_q  <= rw_clken_d;
      rw_half_q   <= rw_half_d;
      rw_rd_q     <= rw_rd_d;
      rw_result_q <= rw_result_d;
    end
  end

  assign bus.rw_clken  = rw_clken_q;
  assign bus.rw_half   = rw_half_q;
  assign bus.rw_rd     = rw_rd_q;
  assign bus.rw_result = rw_result_q;
  assign bus.busy      = (state_q == HIGH);

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_sched.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_regfile_wb_sched : directed vector bench for regfile_wb_sched
// Rev 1.0
// ------------------------------------------------------------------
module tb_regfile_wb_sched;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ares;
    logic        aw;
    logic        ah;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mres;
    logic        mw;
    logic        mh;
    logic        ear;
    logic        emr;
    logic        ece;
    logic        eh;
    logic [4:0]  erd;
    logic [15:0] eres;
    logic        ebusy;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t vecs[32];
  int   nvec;

  regfile_wb_sched_if bus ();

  regfile_wb_sched #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(
    input logic av, input logic [4:0] ard, input logic [31:0] ares, input logic aw, input logic ah,
    input logic mv, input logic [4:0] mrd, input logic [31:0] mres, input logic mw, input logic mh,
    input logic ear, input logic emr, input logic ece, input logic eh,
    input logic [4:0] erd, input logic [15:0] eres, input logic ebusy);
    vecs[nvec] = '{av, ard, ares, aw, ah, mv, mrd, mres, mw, mh, ear, emr, ece, eh, erd, eres, ebusy};
    nvec++;
  endtask

  task automatic drive_idle();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_result = '0; bus.alu_wide = 1'b0; bus.alu_half = 1'b0;
    bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_result = '0; bus.mem_wide = 1'b0; bus.mem_half = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic ece, input logic eh,
                           input logic [4:0] erd, input logic [15:0] eres, input logic ebusy);
    chk({tag, " rw_clken"},  32'(bus.rw_clken),  32'(ece));
    chk({tag, " rw_half"},   32'(bus.rw_half),   32'(eh));
    chk({tag, " rw_rd"},     32'(bus.rw_rd),     32'(erd));
    chk({tag, " rw_result"}, 32'(bus.rw_result), 32'(eres));
    chk({tag, " busy"},      32'(bus.busy),      32'(ebusy));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nvec   = 0;

    //   alu: v rd res wide half | mem: v rd res wide half | exp: ar mr ce h rd res busy
    add(0, 0, 32'h0,         0, 0,  0, 0,  32'h0,         0, 0,  0, 0, 0, 0, 0,  16'h0,    0);
    add(1, 3, 32'h0000_BEEF, 0, 1,  0, 0,  32'h0,         0, 0,  1, 0, 0, 0, 0,  16'h0,    0);
    add(0, 0, 32'h0,         0, 0,  0, 0,  32'h0,         0, 0,  0, 0, 1, 1, 3,  16'hBEEF, 0);
    add(0, 0, 32'h0,         0, 0,  1, 7,  32'h1234_5678, 1, 0,  0, 1, 0, 1, 3,  16'hBEEF, 0);
    add(0, 0, 32'h0,         0, 0,  1, 9,  32'h0000_AAAA, 0, 0,  0, 0, 1, 0, 7,  16'h5678, 1);
    add(0, 0, 32'h0,         0, 0,  1, 9,  32'h0000_AAAA, 0, 0,  0, 1, 1, 1, 7,  16'h1234, 0);
    add(0, 0, 32'h0,         0, 0,  0, 0,  32'h0,         0, 0,  0, 0, 1, 0, 9,  16'hAAAA, 0);
    add(0, 0, 32'h0,         0, 0,  0, 0,  32'h0,         0, 0,  0, 0, 0, 0, 9,  16'hAAAA, 0);
    add(1, 1, 32'h1111_2222, 1, 0,  1, 2,  32'h3333_4444, 1, 0,  0, 1, 0, 0, 9,  16'hAAAA, 0);
    add(1, 1, 32'h1111_2222, 1, 0,  1, 4,  32'h5555_6666, 1, 0,  0, 0, 1, 0, 2,  16'h4444, 1);
    add(1, 1, 32'h1111_2222, 1, 0,  1, 4,  32'h5555_6666, 1, 0,  0, 1, 1, 1, 2,  16'h3333, 0);
    add(1, 1, 32'h1111_2222, 1, 0,  0, 0,  32'h0,         0, 0,  0, 0, 1, 0, 4,  16'h6666, 1);
    add(1, 1, 32'h1111_2222, 1, 0,  0, 0,  32'h0,         0, 0,  1, 0, 1, 1, 4,  16'h5555, 0);
    add(0, 0, 32'h0,         0, 0,  0, 0,  32'h0,         0, 0,  0, 0, 1, 0, 1,  16'h2222, 1);
    add(0, 0, 32'h0,         0, 0,  0, 0,  32'h0,         0, 0,  0, 0, 1, 1, 1,  16'h1111, 0);
    add(1, 0, 32'hDEAD_BEEF, 1, 0,  0, 0,  32'h0,         0, 0,  1, 0, 0, 1, 1,  16'h1111, 0);
    add(1, 5, 32'h0000_0055, 0, 0,  0, 0,  32'h0,         0, 0,  1, 0, 0, 1, 1,  16'h1111, 0);
    add(0, 0, 32'h0,         0, 0,  0, 0,  32'h0,         0, 0,  0, 0, 1, 0, 5,  16'h0055, 0);
    add(1, 6, 32'h0000_0066, 0, 1,  0, 0,  32'h0,         0, 0,  1, 0, 0, 0, 5,  16'h0055, 0);
    add(1, 8, 32'h0000_0077, 0, 0,  0, 0,  32'h0,         0, 0,  1, 0, 1, 1, 6,  16'h0066, 0);
    add(0, 0, 32'h0,         0, 0,  0, 0,  32'h0,         0, 0,  0, 0, 1, 0, 8,  16'h0077, 0);
    add(0, 0, 32'h0,         0, 0,  0, 0,  32'h0,         0, 0,  0, 0, 0, 0, 8,  16'h0077, 0);

    // Reset with a pending request: readies must stay low.
    rst = 1'b1;
    drive_idle();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd3;
    repeat (2) @(negedge clk);
    #1;
    chk("reset alu_ready", 32'(bus.alu_ready), 32'h0);
    chk("reset mem_ready", 32'(bus.mem_ready), 32'h0);
    check_out("reset", 1'b0, 1'b0, 5'd0, 16'h0, 1'b0);
    @(negedge clk);
    drive_idle();
    rst = 1'b0;

    for (int i = 0; i < nvec; i++) begin
      string tag;
      @(negedge clk);
      bus.alu_valid  = vecs[i].av;
      bus.alu_rd     = vecs[i].ard;
      bus.alu_result = vecs[i].ares;
      bus.alu_wide   = vecs[i].aw;
      bus.alu_half   = vecs[i].ah;
      bus.mem_valid  = vecs[i].mv;
      bus.mem_rd     = vecs[i].mrd;
      bus.mem_result = vecs[i].mres;
      bus.mem_wide   = vecs[i].mw;
      bus.mem_half   = vecs[i].mh;
      #1;
      tag = $sformatf("vec%0d", i);
      chk({tag, " alu_ready"}, 32'(bus.alu_ready), 32'(vecs[i].ear));
      chk({tag, " mem_ready"}, 32'(bus.mem_ready), 32'(vecs[i].emr));
      check_out(tag, vecs[i].ece, vecs[i].eh, vecs[i].erd, vecs[i].eres, vecs[i].ebusy);
    end

    // Reset pulsed while the high beat is pending.
    @(negedge clk);
    drive_idle();
    bus.mem_valid  = 1'b1;
    bus.mem_rd     = 5'd10;
    bus.mem_result = 32'hCAFE_F00D;
    bus.mem_wide   = 1'b1;
    #1;
    chk("hirst accept mem_ready", 32'(bus.mem_ready), 32'h1);
    @(negedge clk);
    bus.mem_rd     = 5'd11;
    bus.mem_result = 32'h0000_0011;
    bus.mem_wide   = 1'b0;
    #1;
    check_out("hirst low", 1'b1, 1'b0, 5'd10, 16'hF00D, 1'b1);
    rst = 1'b1;
    #1;
    check_out("hirst during", 1'b0, 1'b0, 5'd0, 16'h0, 1'b0);
    chk("hirst during mem_ready", 32'(bus.mem_ready), 32'h0);
    @(negedge clk);
    drive_idle();
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_out("hirst after1", 1'b0, 1'b0, 5'd0, 16'h0, 1'b0);
    @(negedge clk);
    #1;
    check_out("hirst after2", 1'b0, 1'b0, 5'd0, 16'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_wb_sched.md
# regfile_wb_sched

Write-back scheduler for the split 16-bit register file. Two requesters, the ALU and the load unit, share the file's single write port. The block arbitrates between them and serialises each 32-bit result into low-half and high-half write beats (`rw_half` = 0, then 1). It drives `rw_clken`, `rw_half`, `rw_rd` and `rw_result` directly and sits between the execute/memory stages and the register file.

## Interface
Parameters:
- `XLEN`, 32: request result width. Fixed at 2×16.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-high reset.
- `alu_valid`  in  1  ALU write-back request.
- `alu_ready`  out  1  ALU request accepted this cycle when high together with `alu_valid`.
- `alu_rd`  in  5  destination register.
- `alu_result`  in  32  result value.
- `alu_wide`  in  1  1 = write both halves; 0 = write the single half given by `alu_half`.
- `alu_half`  in  1  half selected for a narrow write; the data is always `alu_result[15:0]`.
- `mem_valid`, `mem_ready`, `mem_rd`, `mem_result`, `mem_wide`, `mem_half`: load-unit request, same meaning and widths as the `alu_*` ports.
- `rw_clken`  out  1  register-file write enable.
- `rw_half`  out  1  half being written.
- `rw_rd`  out  5  register being written.
- `rw_result`  out  16  write data.
- `busy`  out  1  a high beat is pending.

## Operation
- States: `IDLE` and `HIGH` (a wide request's high beat is pending).
- Ready:
  - `alu_ready` and `mem_ready` are combinational.
  - Both are 0 in `HIGH`.
  - In `IDLE`, only the arbitration winner sees ready = 1.
- Arbitration (default): fixed priority, `mem` beats `alu`. A loser keeps `valid` asserted and its payload stable until it is accepted.
- Accepting a narrow request: the next cycle issues one beat with `rw_half` = `*_half` and `rw_result` = `result[15:0]`. The state stays `IDLE`.
- Accepting a wide request:
  - Next cycle issues the low beat (`rw_half` = 0, `result[15:0]`).
  - `result[31:16]` and `rd` are latched, and the state becomes `HIGH`.
  - The cycle after issues the high beat (`rw_half` = 1, `result[31:16]`) and the state returns to `IDLE`.
- Register 0: a request with `rd` = 0 is accepted normally but produces no beats (`rw_clken` stays 0) and never enters `HIGH`.
- Simultaneous events:
  - A request can be accepted in the same cycle the high beat is emitted, because `HIGH` → `IDLE` makes ready valid that cycle.
  - The accepted request's beat follows on the next cycle, so the port never idles.
- Reset: asynchronous assertion forces `IDLE` and discards any latched high half. The pending write is lost; the upstream pipeline is flushed by the same reset.

## Timing
- All `rw_*` outputs and `busy` are registered.
- Reset values: `rw_clken` = 0, `rw_half` = 0, `rw_rd` = 0, `rw_result` = 0, `busy` = 0. The combinational readies are 0 while `rst` is high.
- Latency is accept cycle N → first beat at N+1, and for a wide request the high beat at N+2.
- Throughput:
  - Narrow requests: 1 per cycle.
  - Wide requests: 1 per 2 cycles.
  - `rd` = 0 requests: 1 per cycle, using no port slot.
- `busy` = 1 exactly in the cycles where the state is `HIGH`. That is the cycle that issues the low beat; the high beat is issued in the cycle after it.
- `rw_clken` is 0 in any cycle with no beat. The `rw_rd`, `rw_half` and `rw_result` values are don't-care but hold their last value.

## Configuration
- `REGFILE_WB_RR_EN` defined: round-robin arbitration.
  - One priority bit flips after every accepted request when both requesters were valid.
  - After reset, `mem` has priority.
- Undefined: fixed `mem` > `alu` priority, with no priority state flop.

## Structure
- `regfile_pkg` holds:
  - `reg_idx_t` (5 bits) and `half_t` (16 bits).
  - `wb_req_t` struct {`rd`, `result`, `wide`, `half`}.
  - `wb_state_e` enum {`IDLE`, `HIGH`}.
- Sub-module `regfile_wb_pick`: a combinational two-way picker. It takes both valids and the priority bit and returns the grant one-hot. It is instantiated once, with priority tied to `mem` when `REGFILE_WB_RR_EN` is undefined.

## Test plan
- Narrow ALU request (rd = 3, half = 1, result = 0x0000_BEEF) → next cycle: `rw_clken` = 1, `rw_half` = 1, `rw_rd` = 3, `rw_result` = 0xBEEF; `busy` stays 0.
- Wide mem request (rd = 7, result = 0x1234_5678) → beat 0x5678/half 0, then 0x1234/half 1; `busy` = 1 for one cycle; `mem_ready` = 0 in between.
- Both valid each cycle, all wide:
  - Default build: all mem requests complete before any ALU request.
  - With `REGFILE_WB_RR_EN`: grants alternate mem, alu, mem, …
- Request with rd = 0 (wide) → accepted, no `rw_clken`, the next request is accepted the following cycle.
- Back-to-back: wide request then narrow request held valid → narrow accepted on the high-beat cycle, its beat directly follows with no idle cycle.
- `rst` pulsed while in `HIGH` → `rw_clken` = 0 immediately; no high beat after release; the state is `IDLE`.
